hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core; consumes the decoded control bundle produced in ID (`reg_write`, `mem_read`, `ctrl_transfer`) plus register addresses, and drives stall, bubble, flush and forwarding selects back into the pipeline. It keeps its own shadow copy of the EX/MEM/WB control state so that hazard decisions never depend on datapath registers. It also counts lost cycles for performance debug.

## Interface

- `REG_AW`, 5, register address width
- `CNT_W`, 16, width of the saturating performance counters
- `clk`  in  1  core clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `id_valid`  in  1  ID stage holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_AW  source registers of the ID instruction
- `id_rd`  in  REG_AW  destination register of the ID instruction
- `id_reg_write`, `id_mem_read`  in  1  decoder outputs for the ID instruction
- `id_ctrl_transfer`  in  2  decoder output: 00 none, 01 branch, 10 JAL, 11 JALR
- `ex_redirect`  in  1  branch unit in EX: control transfer taken this cycle
- `stall_if_id`  out  1  hold PC and the IF/ID register
- `bubble_id_ex`  out  1  load a NOP into ID/EX (hazard stall)
- `flush_if_id`, `flush_id_ex`  out  1  squash the IF/ID and ID/EX contents
- `fwd_a`, `fwd_b`  out  2  ALU operand source for the EX instruction: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating counts of stall and flush cycles

## Operation

- Shadow stages EX, MEM, WB each hold {valid, rd, reg_write, mem_read, ctrl_transfer}; EX also holds rs1, rs2.
- Each edge: WB<=MEM, MEM<=EX; EX<=ID bundle with valid=`id_valid`, except EX.valid<=0 when `bubble_id_ex` or `flush_id_ex`.
- Load-use: `hz` = id_valid & EX.valid & EX.mem_read & EX.rd!=0 & (EX.rd==id_rs1 | EX.rd==id_rs2); both sources compared regardless of format.
- Forwarding (per operand, shown for A with EX.rs1): MEM.valid & MEM.reg_write & !MEM.mem_read & MEM.rd!=0 & MEM.rd==EX.rs1 -> 01; else WB.valid & WB.reg_write & WB.rd!=0 & WB.rd==EX.rs1 -> 10; else 00. MEM beats WB. x0 never forwarded.
- FSM states RUN, LU_STALL, FLUSH:
  - RUN: `ex_redirect` -> FLUSH; else `hz` -> LU_STALL; else RUN.
  - LU_STALL: `ex_redirect` -> FLUSH; else RUN (stall never exceeds one cycle per load).
  - FLUSH: `id_valid` treated as 0 for this cycle (no `hz`, EX.valid<=0); `ex_redirect` -> FLUSH, else RUN.
- Outputs (combinational from state and inputs): `flush_if_id`=`flush_id_ex`=`ex_redirect`; `stall_if_id`=`bubble_id_ex`=`hz` & !`ex_redirect` & state!=FLUSH.
- Redirect beats load-use stall when simultaneous: no stall, both flushes asserted.
- `stall_cnt` +1 each cycle `stall_if_id`=1; `flush_cnt` +1 each cycle `ex_redirect`=1; both saturate at all-ones.

## Timing

- Stall, bubble, flush and forward outputs valid in the same cycle as their causes (zero latency); shadow state and counters update on the next edge.
- A load followed immediately by a dependent instruction costs exactly one stall cycle; the consumer then sees `fwd`=10.
- Reset (sampled high at an edge): state RUN, all shadow valid=0, counters 0. While `reset` is high all outputs forced 0 (`fwd_*`=00). Reset during LU_STALL or FLUSH drops the pending action; the first cycle after reset is RUN.
- `ctrl_transfer` shadow carried for debug only; it does not affect outputs.

## Test plan

- `lw x5` in EX, ID `add x6,x5,x1` -> cycle 0 `stall_if_id`=`bubble_id_ex`=1; cycle 1 stall=0, EX `add` gets `fwd_a`=10; `stall_cnt`=1.
- `add x3,..` then `sub x4,x3,x3` back-to-back -> no stall; `fwd_a`=`fwd_b`=01 when `sub` is in EX.
- x3 written in both MEM and WB, EX reads x3 -> `fwd`=01 (MEM priority); writes to x0 with rs1=0 -> `fwd_a`=00, no load-use stall for `lw x0`.
- `ex_redirect`=1 in the same cycle as a load-use hazard -> `flush_if_id`=`flush_id_ex`=1, `stall_if_id`=0; next cycle state FLUSH, `id_valid` ignored; `flush_cnt`=1.
- `reset` asserted during LU_STALL -> all outputs 0 that cycle; after release, state RUN, counters 0, no forwarding from pre-reset shadow contents.
- Force `stall_cnt` to 0xFFFF via 65535 stalls -> further stalls leave it at 0xFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage RISC-V core.
//
// Keeps a shadow copy of the EX/MEM/WB control bundles and uses it to
// detect load-use hazards, select ALU operand forwarding and sequence
// flushes after a taken control transfer. It also counts stall and flush
// cycles in saturating counters for performance debug.
//
// Ports
//   clk_i               core clock, all state updates on the rising edge
//   reset_i             synchronous, active-high
//   id_valid_i          ID stage holds a real instruction
//   id_rs1_i/id_rs2_i   ID source registers
//   id_rd_i             ID destination register
//   id_reg_write_i      ID instruction writes the register file
//   id_mem_read_i       ID instruction is a load
//   id_ctrl_transfer_i  00 none, 01 branch, 10 JAL, 11 JALR (debug only)
//   ex_redirect_i       branch unit in EX takes a control transfer
//   stall_if_id_o       hold PC and IF/ID
//   bubble_id_ex_o      load a NOP into ID/EX
//   flush_if_id_o       squash IF/ID
//   flush_id_ex_o       squash ID/EX
//   fwd_a_o/fwd_b_o     EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt_o         saturating count of stall cycles
//   flush_cnt_o         saturating count of flush cycles
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_RUN      | normal flow, hazards evaluated every cycle
// S_LU_STALL | one bubble inserted behind a load, consumer re-evaluated
// S_FLUSH    | previous cycle redirected, ID contents are wrong-path

module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic [1:0]        id_ctrl_transfer_i,
  input  logic              ex_redirect_i,
  output logic              stall_if_id_o,
  output logic              bubble_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [1:0]        ctrl_transfer;
  } stage_t;

  state_t            state_q, state_d;
  stage_t            ex_q, mem_q, wb_q, ex_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       id_valid_eff;
  logic       hz;
  logic       stall_raw;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // MEM result wins over WB; a load in MEM has no data yet, so it is skipped.
  function automatic logic [1:0] fwd_sel(input stage_t mem_s, input stage_t wb_s,
                                         input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_s.valid && mem_s.reg_write && !mem_s.mem_read &&
        (mem_s.rd != '0) && (mem_s.rd == src)) begin
      sel = 2'b01;
    end else if (wb_s.valid && wb_s.reg_write &&
                 (wb_s.rd != '0) && (wb_s.rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    id_valid_eff = id_valid_i && (state_q != S_FLUSH);
    // Both sources compared regardless of instruction format: a false stall
    // costs one cycle, a missed one corrupts data.
    hz = id_valid_eff && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
         ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    stall_raw = hz && !ex_redirect_i;
    fwd_a_raw = fwd_sel(mem_q, wb_q, ex_rs1_q);
    fwd_b_raw = fwd_sel(mem_q, wb_q, ex_rs2_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (ex_redirect_i)  state_d = S_FLUSH;
        else if (hz)        state_d = S_LU_STALL;
        else                state_d = S_RUN;
      end
      S_LU_STALL: state_d = ex_redirect_i ? S_FLUSH : S_RUN;
      S_FLUSH:    state_d = ex_redirect_i ? S_FLUSH : S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  always_comb begin
    ex_d.valid         = id_valid_eff && !stall_raw && !ex_redirect_i;
    ex_d.rd            = id_rd_i;
    ex_d.reg_write     = id_reg_write_i;
    ex_d.mem_read      = id_mem_read_i;
    ex_d.ctrl_transfer = id_ctrl_transfer_i;

    stall_cnt_d = stall_cnt_q;
    if (stall_raw && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (ex_redirect_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      ex_rs1_q    <= id_rs1_i;
      ex_rs2_q    <= id_rs2_i;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Everything is held at zero while reset is asserted, even before the edge.
  assign stall_if_id_o  = !reset_i && stall_raw;
  assign bubble_id_ex_o = !reset_i && stall_raw;
  assign flush_if_id_o  = !reset_i && ex_redirect_i;
  assign flush_id_ex_o  = !reset_i && ex_redirect_i;
  assign fwd_a_o        = reset_i ? 2'b00 : fwd_a_raw;
  assign fwd_b_o        = reset_i ? 2'b00 : fwd_b_raw;
  assign stall_cnt_o    = reset_i ? '0 : stall_cnt_q;
  assign flush_cnt_o    = reset_i ? '0 : flush_cnt_q;

  // WB ctrl_transfer/mem_read are retained for debug visibility only.
  logic unused_dbg;
  assign unused_dbg = ^{wb_q.ctrl_transfer, wb_q.mem_read};

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_read;
  logic [1:0]        id_ctrl_transfer;
  logic              ex_redirect;
  logic              stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .id_valid_i         (id_valid),
    .id_rs1_i           (id_rs1),
    .id_rs2_i           (id_rs2),
    .id_rd_i            (id_rd),
    .id_reg_write_i     (id_reg_write),
    .id_mem_read_i      (id_mem_read),
    .id_ctrl_transfer_i (id_ctrl_transfer),
    .ex_redirect_i      (ex_redirect),
    .stall_if_id_o      (stall_if_id),
    .bubble_id_ex_o     (bubble_id_ex),
    .flush_if_id_o      (flush_if_id),
    .flush_id_ex_o      (flush_id_ex),
    .fwd_a_o            (fwd_a),
    .fwd_b_o            (fwd_b),
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instructions occupying EX, MEM, WB, plus whether
  // the previous cycle redirected (which makes the current ID wrong-path).
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       rw;
    bit       mr;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  bit   m_wrong_path;
  int   m_scnt, m_fcnt;
  bit   cur_live, cur_stall;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int src_of(input bit [4:0] r);
    if (m_mem.v && m_mem.rw && !m_mem.mr && r != 0 && m_mem.rd == r) return 1;
    if (m_wb.v && m_wb.rw && r != 0 && m_wb.rd == r) return 2;
    return 0;
  endfunction

  // Drive one cycle of inputs, then compare every output with the model.
  task automatic apply(input bit rst, input bit v, input bit [4:0] rd,
                       input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit rw, input bit mr, input bit redir);
    bit hz;
    reset            = rst;
    id_valid         = v;
    id_rd            = rd;
    id_rs1           = rs1;
    id_rs2           = rs2;
    id_reg_write     = rw;
    id_mem_read      = mr;
    id_ctrl_transfer = 2'($urandom_range(0, 3));
    ex_redirect      = redir;
    #1;
    cur_live  = v && !m_wrong_path;
    hz        = cur_live && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
                (m_ex.rd == rs1 || m_ex.rd == rs2);
    cur_stall = hz && !redir;
    chk("stall_if_id",  32'(stall_if_id),  rst ? 0 : 32'(cur_stall));
    chk("bubble_id_ex", 32'(bubble_id_ex), rst ? 0 : 32'(cur_stall));
    chk("flush_if_id",  32'(flush_if_id),  rst ? 0 : 32'(redir));
    chk("flush_id_ex",  32'(flush_id_ex),  rst ? 0 : 32'(redir));
    chk("fwd_a",        32'(fwd_a),        rst ? 0 : src_of(m_ex.rs1));
    chk("fwd_b",        32'(fwd_b),        rst ? 0 : src_of(m_ex.rs2));
    chk("stall_cnt",    32'(stall_cnt),    rst ? 0 : m_scnt);
    chk("flush_cnt",    32'(flush_cnt),    rst ? 0 : m_fcnt);
  endtask

  // Clock edge: advance the model with the inputs currently applied.
  task automatic adv();
    @(posedge clk);
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      m_wrong_path = 0;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex.v   = cur_live && !cur_stall && !ex_redirect;
      m_ex.rd  = id_rd;
      m_ex.rs1 = id_rs1;
      m_ex.rs2 = id_rs2;
      m_ex.rw  = id_reg_write;
      m_ex.mr  = id_mem_read;
      m_wrong_path = ex_redirect;
      if (cur_stall && m_scnt < CNT_MAX) m_scnt++;
      if (ex_redirect && m_fcnt < CNT_MAX) m_fcnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_wrong_path = 0; m_scnt = 0; m_fcnt = 0;
    cur_live = 0; cur_stall = 0;
    reset = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_ctrl_transfer = 0; ex_redirect = 0;
    @(negedge clk);

    // Reset
    apply(1, 0, 0, 0, 0, 0, 0, 0); adv();
    apply(1, 0, 0, 0, 0, 0, 0, 0); adv();

    // lw x5 ; add x6,x5,x1 -> one stall, consumer forwards from WB
    apply(0, 1, 5, 0, 0, 1, 1, 0); adv();
    apply(0, 1, 6, 5, 1, 1, 0, 0);
    chk("lu_stall_c0", 32'(stall_if_id), 1);
    chk("lu_bubble_c0", 32'(bubble_id_ex), 1);
    adv();
    apply(0, 1, 6, 5, 1, 1, 0, 0);
    chk("lu_stall_c1", 32'(stall_if_id), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a", 32'(fwd_a), 2);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    adv();

    // add x3 ; sub x4,x3,x3 -> forwarding from MEM on both operands
    apply(0, 1, 3, 1, 2, 1, 0, 0); adv();
    apply(0, 1, 4, 3, 3, 1, 0, 0);
    chk("b2b_no_stall", 32'(stall_if_id), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_fwd_a", 32'(fwd_a), 1);
    chk("b2b_fwd_b", 32'(fwd_b), 1);
    adv();

    // x3 in MEM and WB -> MEM priority
    apply(0, 1, 3, 1, 1, 1, 0, 0); adv();
    apply(0, 1, 3, 2, 2, 1, 0, 0); adv();
    apply(0, 1, 7, 3, 0, 1, 0, 0); adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("prio_fwd_a", 32'(fwd_a), 1);
    chk("prio_fwd_b", 32'(fwd_b), 0);
    adv();

    // x0 is never forwarded and lw x0 causes no stall
    apply(0, 1, 0, 1, 1, 1, 0, 0); adv();
    apply(0, 1, 0, 1, 1, 1, 1, 0); adv();
    apply(0, 1, 8, 0, 0, 1, 0, 0);
    chk("x0_no_stall", 32'(stall_if_id), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_fwd_a", 32'(fwd_a), 0);
    adv();

    // Redirect together with a load-use hazard
    apply(0, 1, 5, 0, 0, 1, 1, 0); adv();
    apply(0, 1, 6, 5, 5, 1, 0, 1);
    chk("redir_flush_if", 32'(flush_if_id), 1);
    chk("redir_flush_ex", 32'(flush_id_ex), 1);
    chk("redir_no_stall", 32'(stall_if_id), 0);
    adv();
    apply(0, 1, 9, 0, 0, 1, 1, 0);   // wrong-path load, must be dropped
    chk("flush_state_no_flush", 32'(flush_if_id), 0);
    adv();
    apply(0, 1, 10, 9, 9, 1, 0, 0);
    chk("flush_ignored_id", 32'(stall_if_id), 0);
    chk("flush_cnt_one", 32'(flush_cnt), 1);
    adv();

    // Reset while in LU_STALL
    apply(0, 1, 3, 1, 1, 1, 0, 0); adv();
    apply(0, 1, 5, 0, 0, 1, 1, 0); adv();
    apply(0, 1, 6, 5, 3, 1, 0, 0);
    chk("pre_rst_stall", 32'(stall_if_id), 1);
    adv();
    apply(1, 1, 6, 3, 5, 1, 0, 1);
    chk("rst_stall", 32'(stall_if_id), 0);
    chk("rst_flush", 32'(flush_if_id), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    adv();
    apply(0, 1, 11, 3, 5, 1, 0, 0);
    chk("post_rst_no_stall", 32'(stall_if_id), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_fwd_a", 32'(fwd_a), 0);
    chk("post_rst_fwd_b", 32'(fwd_b), 0);
    chk("post_rst_cnt", 32'(stall_cnt), 0);
    adv();

    // Randomized traffic, small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
      adv();
    end

    // Counter saturation
    apply(1, 0, 0, 0, 0, 0, 0, 0); adv();
    for (int i = 0; i < 600; i++) begin
      apply(0, 1, 5, 5, 0, 1, 1, 0);
      adv();
    end
    apply(0, 1, 5, 5, 0, 1, 1, 0);
    chk("stall_sat", 32'(stall_cnt), CNT_MAX);
    adv();
    apply(0, 1, 5, 5, 0, 1, 1, 0); adv();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_sat_hold", 32'(stall_cnt), CNT_MAX);
    adv();
    for (int i = 0; i < 300; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      adv();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_sat", 32'(flush_cnt), CNT_MAX);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
